// File: rtl/pulse_train_gen_pkg.sv
// General: shared helpers and types for the pulse train generator.
//   clog2             - ceiling log2, for deriving port widths from maxima
//   PulseTrainState_t - burst FSM states
package General;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic [1:0] {IDLE, HIGH, LOW} PulseTrainState_t;

endpackage

// File: rtl/pulse_train_gen_phase_timer.sv
// phase_timer: loadable down-counter timing one HIGH or LOW phase.
//   clk_i, nReset_i - clock, async active-low reset
//   load_i, value_i - start a phase of value_i cycles (value_i >= 1)
//   clear_i         - park the counter at 0 (no expiry)
//   expire_o        - high on the last cycle of the current phase
module phase_timer #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         nReset_i,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         clear_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Holds at 1 instead of wrapping; the owner always reloads or clears on expiry.
  always_comb
    cnt_d = clear_i ? '0 : load_i ? value_i : (cnt_q > W'(1)) ? cnt_q - W'(1) : cnt_q;

  always_ff @(posedge clk_i or negedge nReset_i)
    if (!nReset_i) cnt_q <= '0;
    else cnt_q <= cnt_d;

  assign expire_o = cnt_q == W'(1);
endmodule

// File: rtl/pulse_train_gen.sv
// pulse_train_gen: expands one start command into a burst of N evenly spaced step pulses.
//   clk_i, nReset_i      - clock, async active-low reset
//   start_i              - command strobe, sampled only while idle
//   count_i, period_i    - burst length and rising-edge spacing, sampled with start_i
//   abort_i              - ends an active burst without done_o
//   pulse_o, busy_o      - registered step pulse and burst-active flag
//   done_o               - one-cycle strobe on normal completion (or zero-length start)
//   remaining_o          - pulses not yet started
module pulse_train_gen
  import General::*;
#(
  parameter int  MAX_PULSES  = 1023,
  parameter int  MAX_PERIOD  = 65535,
  parameter int  HIGH_CYCLES = 1,
  localparam int CNT_W       = clog2(MAX_PULSES + 1),
  localparam int PER_W       = clog2(MAX_PERIOD + 1)
) (
  input  logic             clk_i,
  input  logic             nReset_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [PER_W-1:0] period_i,
  input  logic             abort_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] remaining_o
);
  localparam logic [PER_W-1:0] HIGH_LEN = PER_W'(HIGH_CYCLES);
  localparam logic [PER_W-1:0] MIN_PER  = PER_W'(HIGH_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PULSES);

  PulseTrainState_t state_q, state_d;
  logic [PER_W-1:0] per_q, per_d, per_eff, tmr_value;
  logic [CNT_W-1:0] rem_q, rem_d, cnt_eff;
  logic             pulse_q, pulse_d, busy_q, busy_d, done_q, done_d;
  logic             tmr_load, tmr_clear, tmr_expire;

  // Compare in 32 bits so a non-power-of-two maximum still clamps.
  assign cnt_eff = (32'(count_i) > MAX_PULSES) ? MAX_CNT : count_i;
  assign per_eff = (period_i < MIN_PER) ? MIN_PER : period_i;

  phase_timer #(.W(PER_W)) u_timer (
    .clk_i   (clk_i),
    .nReset_i(nReset_i),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .clear_i (tmr_clear),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    rem_d     = rem_q;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_value = HIGH_LEN;
    if (state_q == IDLE) begin
      if (start_i && count_i == '0) done_d = 1'b1;
      else if (start_i) begin
        state_d  = HIGH;
        per_d    = per_eff;
        rem_d    = cnt_eff - CNT_W'(1);
        pulse_d  = 1'b1;
        busy_d   = 1'b1;
        tmr_load = 1'b1;
      end
    end else if (abort_i) begin
      state_d   = IDLE;
      rem_d     = '0;
      pulse_d   = 1'b0;
      busy_d    = 1'b0;
      tmr_clear = 1'b1;
    end else if (tmr_expire) begin
      if (state_q == HIGH) begin
        state_d   = LOW;
        pulse_d   = 1'b0;
        tmr_load  = 1'b1;
        tmr_value = per_q - HIGH_LEN;
      end else if (rem_q != '0) begin
        state_d  = HIGH;
        rem_d    = rem_q - CNT_W'(1);
        pulse_d  = 1'b1;
        tmr_load = 1'b1;
      end else begin
        // The final low phase runs in full so chained bursts keep their spacing.
        state_d   = IDLE;
        busy_d    = 1'b0;
        done_d    = 1'b1;
        tmr_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nReset_i)
    if (!nReset_i) begin
      state_q <= IDLE;
      per_q   <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      rem_q   <= rem_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end

  assign pulse_o     = pulse_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign remaining_o = rem_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// tb_pulse_train_gen: directed self-checking bench for pulse_train_gen.
module tb_pulse_train_gen;
  logic        clk = 1'b0, rst_n = 1'b1;
  logic        start = 1'b0, abort = 1'b0, start2 = 1'b0;
  logic [9:0]  count = '0, count2 = '0;
  logic [15:0] period = '0, period2 = '0;
  logic        pulse, busy, done, pulse2, busy2, done2;
  logic [9:0]  rem, rem2;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  pulse_train_gen dut (
    .clk_i(clk), .nReset_i(rst_n), .start_i(start), .count_i(count), .period_i(period),
    .abort_i(abort), .pulse_o(pulse), .busy_o(busy), .done_o(done), .remaining_o(rem)
  );

  pulse_train_gen #(.HIGH_CYCLES(2)) dut2 (
    .clk_i(clk), .nReset_i(rst_n), .start_i(start2), .count_i(count2), .period_i(period2),
    .abort_i(1'b0), .pulse_o(pulse2), .busy_o(busy2), .done_o(done2), .remaining_o(rem2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [2:0] e;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pulse, busy, done, rem, pulse2, busy2, done2, rem2} !== '0) begin
      errors++;
      $display("FAIL reset_async outputs=%b required all zero", {pulse, busy, done, rem, pulse2, busy2, done2, rem2});
    end
    start = 1'b1; count = 10'd1; period = 16'd2;
    for (int c = 1; c <= 2; c++) begin
      tick();
      checks++;
      if ({pulse, busy, done, rem} !== '0) begin
        errors++;
        $display("FAIL reset_held cycle %0d outputs=%b required zero", c, {pulse, busy, done, rem});
      end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      start = 1'b0;
      e = {c == 1, c <= 2, c == 3};
      checks++;
      if ({pulse, busy, done} !== e) begin
        errors++;
        $display("FAIL reset_release cycle %0d pulse/busy/done=%b required %b", c, {pulse, busy, done}, e);
      end
    end
  endtask

  task automatic test_basic;
    logic [2:0] e;
    start = 1'b1; count = 10'd3; period = 16'd4;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = 1'b0;
      e = {c == 1 || c == 5 || c == 9, c <= 12, c == 13};
      checks++;
      if ({pulse, busy, done} !== e) begin
        errors++;
        $display("FAIL basic cycle %0d pulse/busy/done=%b required %b", c, {pulse, busy, done}, e);
      end
      if (c == 1 || c == 5 || c == 9) begin
        checks++;
        if (rem !== 10'((9 - c) / 4)) begin
          errors++;
          $display("FAIL basic_remaining cycle %0d got %0d required %0d", c, rem, (9 - c) / 4);
        end
      end
    end
  endtask

  task automatic test_period_clamp;
    logic [2:0] e;
    start2 = 1'b1; count2 = 10'd2; period2 = 16'd1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      start2 = 1'b0;
      e = {c == 1 || c == 2 || c == 4 || c == 5, c <= 6, c == 7};
      checks++;
      if ({pulse2, busy2, done2} !== e) begin
        errors++;
        $display("FAIL clamp cycle %0d pulse/busy/done=%b required %b", c, {pulse2, busy2, done2}, e);
      end
    end
  endtask

  task automatic test_zero_and_ignored;
    logic [2:0] e;
    start = 1'b1; count = 10'd0; period = 16'd4;
    for (int c = 1; c <= 2; c++) begin
      tick();
      start = 1'b0;
      e = {1'b0, 1'b0, c == 1};
      checks++;
      if ({pulse, busy, done} !== e) begin
        errors++;
        $display("FAIL zero_count cycle %0d pulse/busy/done=%b required %b", c, {pulse, busy, done}, e);
      end
    end
    start = 1'b1; count = 10'd3; period = 16'd4;
    for (int c = 1; c <= 14; c++) begin
      tick();
      start = c == 2;
      if (c == 2) begin count = 10'd5; period = 16'd2; end
      e = {c == 1 || c == 5 || c == 9, c <= 12, c == 13};
      checks++;
      if ({pulse, busy, done} !== e) begin
        errors++;
        $display("FAIL ignored_start cycle %0d pulse/busy/done=%b required %b", c, {pulse, busy, done}, e);
      end
    end
  endtask

  task automatic test_abort;
    logic [2:0] e;
    start = 1'b1; count = 10'd5; period = 16'd4;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start = c == 7;
      abort = c == 6 || c == 7;
      if (c == 7) count = 10'd1;
      e = {c == 1 || c == 5 || c == 8, c <= 6 || (c >= 8 && c <= 11), c == 12};
      checks++;
      if ({pulse, busy, done} !== e) begin
        errors++;
        $display("FAIL abort cycle %0d pulse/busy/done=%b required %b", c, {pulse, busy, done}, e);
      end
      if (c == 5 || c == 7) begin
        checks++;
        if (rem !== 10'(c == 5 ? 3 : 0)) begin
          errors++;
          $display("FAIL abort_remaining cycle %0d got %0d required %0d", c, rem, c == 5 ? 3 : 0);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] e;
    start = 1'b1; count = 10'd2; period = 16'd4;
    for (int c = 1; c <= 19; c++) begin
      tick();
      start = c == 9;
      e = {c == 1 || c == 5 || c == 10 || c == 14, c <= 8 || (c >= 10 && c <= 17), c == 9 || c == 18};
      checks++;
      if ({pulse, busy, done} !== e) begin
        errors++;
        $display("FAIL back_to_back cycle %0d pulse/busy/done=%b required %b", c, {pulse, busy, done}, e);
      end
      if (c == 10) begin
        checks++;
        if (rem !== 10'd1) begin
          errors++;
          $display("FAIL back_to_back_remaining cycle %0d got %0d required 1", c, rem);
        end
      end
    end
  endtask

  task automatic test_async_reset_mid_pulse;
    logic [2:0] e;
    start = 1'b1; count = 10'd3; period = 16'd4;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    checks++;
    if (pulse !== 1'b1) begin
      errors++;
      $display("FAIL midpulse_setup pulse=%b required 1", pulse);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pulse, busy, done, rem} !== '0) begin
      errors++;
      $display("FAIL midpulse_async outputs=%b required zero", {pulse, busy, done, rem});
    end
    tick();
    rst_n = 1'b1;
    start = 1'b1; count = 10'd1; period = 16'd2;
    for (int c = 1; c <= 3; c++) begin
      tick();
      start = 1'b0;
      e = {c == 1, c <= 2, c == 3};
      checks++;
      if ({pulse, busy, done} !== e) begin
        errors++;
        $display("FAIL midpulse_restart cycle %0d pulse/busy/done=%b required %b", c, {pulse, busy, done}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_period_clamp();
    test_zero_and_ignored();
    test_abort();
    test_back_to_back();
    test_async_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
